// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and PC/immediate operand select.
// Drives the ALU a/b/control inputs behind a valid/ready handshake so EX can stall decode.
module alu_operand_stage #(
    parameter int XLEN    = 32,
    parameter int REGBITS = 5,
    parameter int CTRLW   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    output logic               id_ready,
    input  logic [REGBITS-1:0] id_rs1,
    input  logic [REGBITS-1:0] id_rs2,
    input  logic [REGBITS-1:0] id_rd,
    input  logic [XLEN-1:0]    id_rd1,
    input  logic [XLEN-1:0]    id_rd2,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [1:0]         id_srca,
    input  logic               id_srcb,
    input  logic [CTRLW-1:0]   id_alucontrol,
    input  logic               id_regwrite,
    input  logic               flush,
    input  logic               mem_regwrite,
    input  logic [REGBITS-1:0] mem_rd,
    input  logic [XLEN-1:0]    mem_result,
    input  logic               wb_regwrite,
    input  logic [REGBITS-1:0] wb_rd,
    input  logic [XLEN-1:0]    wb_result,
    output logic               ex_valid,
    input  logic               ex_ready,
    output logic [XLEN-1:0]    alu_a,
    output logic [XLEN-1:0]    alu_b,
    output logic [CTRLW-1:0]   alu_control,
    output logic [REGBITS-1:0] ex_rd,
    output logic               ex_regwrite,
    output logic [XLEN-1:0]    ex_pc,
    output logic [XLEN-1:0]    ex_imm,
    output logic [XLEN-1:0]    ex_store_data
);

    logic               ex_valid_q, ex_valid_d;
    logic [REGBITS-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [XLEN-1:0]    rd1_q, rd1_d, rd2_q, rd2_d;
    logic [XLEN-1:0]    imm_q, imm_d, pc_q, pc_d;
    logic [1:0]         srca_q, srca_d;
    logic               srcb_q, srcb_d;
    logic [CTRLW-1:0]   ctrl_q, ctrl_d;
    logic               regwrite_q, regwrite_d;
    logic [XLEN-1:0]    fwd_rs1_s, fwd_rs2_s;

    // Newest producer wins: MEM over WB over the stored register-file value; x0 never forwards.
    function automatic logic [XLEN-1:0] fwd_value(
        input logic [REGBITS-1:0] rs,
        input logic [XLEN-1:0]    stored,
        input logic               m_we,
        input logic [REGBITS-1:0] m_rd,
        input logic [XLEN-1:0]    m_val,
        input logic               w_we,
        input logic [REGBITS-1:0] w_rd,
        input logic [XLEN-1:0]    w_val
    );
        logic [XLEN-1:0] r;
        if (m_we && (m_rd == rs) && (rs != {REGBITS{1'b0}})) begin
            r = m_val;
        end else if (w_we && (w_rd == rs) && (rs != {REGBITS{1'b0}})) begin
            r = w_val;
        end else begin
            r = stored;
        end
        return r;
    endfunction

    assign id_ready = ~ex_valid_q | ex_ready;

    // Forwarded operands and ALU operand muxes.
    always_comb begin
        fwd_rs1_s = fwd_value(rs1_q, rd1_q, mem_regwrite, mem_rd, mem_result,
                              wb_regwrite, wb_rd, wb_result);
        fwd_rs2_s = fwd_value(rs2_q, rd2_q, mem_regwrite, mem_rd, mem_result,
                              wb_regwrite, wb_rd, wb_result);
        case (srca_q)
            2'b01:   alu_a = pc_q;
            2'b10:   alu_a = {XLEN{1'b0}};
            default: alu_a = fwd_rs1_s;
        endcase
        if (srcb_q) begin
            alu_b = imm_q;
        end else begin
            alu_b = fwd_rs2_s;
        end
    end

    // Next-state: flush kills, accept loads, stall refreshes stored operands from forwarding.
    always_comb begin
        ex_valid_d = ex_valid_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        rd1_d      = rd1_q;
        rd2_d      = rd2_q;
        imm_d      = imm_q;
        pc_d       = pc_q;
        srca_d     = srca_q;
        srcb_d     = srcb_q;
        ctrl_d     = ctrl_q;
        regwrite_d = regwrite_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (id_ready) begin
            ex_valid_d = id_valid;
            if (id_valid) begin
                rs1_d      = id_rs1;
                rs2_d      = id_rs2;
                rd_d       = id_rd;
                rd1_d      = id_rd1;
                rd2_d      = id_rd2;
                imm_d      = id_imm;
                pc_d       = id_pc;
                srca_d     = id_srca;
                srcb_d     = id_srcb;
                ctrl_d     = id_alucontrol;
                regwrite_d = id_regwrite;
            end else begin
                ex_valid_d = 1'b0;
            end
        end else begin
            rd1_d = fwd_rs1_s;
            rd2_d = fwd_rs2_s;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q <= 1'b0;
            rs1_q      <= {REGBITS{1'b0}};
            rs2_q      <= {REGBITS{1'b0}};
            rd_q       <= {REGBITS{1'b0}};
            rd1_q      <= {XLEN{1'b0}};
            rd2_q      <= {XLEN{1'b0}};
            imm_q      <= {XLEN{1'b0}};
            pc_q       <= {XLEN{1'b0}};
            srca_q     <= 2'b00;
            srcb_q     <= 1'b0;
            ctrl_q     <= {CTRLW{1'b0}};
            regwrite_q <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            rd1_q      <= rd1_d;
            rd2_q      <= rd2_d;
            imm_q      <= imm_d;
            pc_q       <= pc_d;
            srca_q     <= srca_d;
            srcb_q     <= srcb_d;
            ctrl_q     <= ctrl_d;
            regwrite_q <= regwrite_d;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign alu_control   = ctrl_q;
    assign ex_rd         = rd_q;
    assign ex_regwrite   = regwrite_q;
    assign ex_pc         = pc_q;
    assign ex_imm        = imm_q;
    assign ex_store_data = fwd_rs2_s;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: an instruction-record model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_ready;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rd1, id_rd2, id_imm, id_pc;
    logic [1:0]  id_srca;
    logic        id_srcb;
    logic [3:0]  id_alucontrol;
    logic        id_regwrite, flush;
    logic        mem_regwrite, wb_regwrite;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] mem_result, wb_result;
    logic        ex_valid, ex_ready;
    logic [31:0] alu_a, alu_b, ex_pc, ex_imm, ex_store_data;
    logic [3:0]  alu_control;
    logic [4:0]  ex_rd;
    logic        ex_regwrite;

    int n_vec = 0;
    int n_bad = 0;

    alu_operand_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rd1(id_rd1), .id_rd2(id_rd2),
        .id_imm(id_imm), .id_pc(id_pc), .id_srca(id_srca), .id_srcb(id_srcb),
        .id_alucontrol(id_alucontrol), .id_regwrite(id_regwrite), .flush(flush),
        .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .alu_a(alu_a), .alu_b(alu_b),
        .alu_control(alu_control), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_store_data(ex_store_data)
    );

    always #5 clk = ~clk;

    // Model: the instruction currently sitting in EX, with its latest known operand values.
    typedef struct packed {
        logic        valid;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] v1, v2, imm, pc;
        logic [1:0]  srca;
        logic        srcb;
        logic [3:0]  ctrl;
        logic        we;
    } instr_t;

    instr_t m;

    function automatic logic [31:0] newest(input logic [4:0] rs, input logic [31:0] v);
        if (rs == 5'd0)                        return v;
        if (mem_regwrite && mem_rd == rs)      return mem_result;
        if (wb_regwrite && wb_rd == rs)        return wb_result;
        return v;
    endfunction

    function automatic logic [31:0] exp_a();
        if (m.srca == 2'b01) return m.pc;
        if (m.srca == 2'b10) return 32'd0;
        return newest(m.rs1, m.v1);
    endfunction

    function automatic logic [31:0] exp_b();
        return m.srcb ? m.imm : newest(m.rs2, m.v2);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m <= '0;
        end else if (flush) begin
            m.valid <= 1'b0;
        end else if (!m.valid || ex_ready) begin
            m.valid <= id_valid;
            if (id_valid)
                m <= '{1'b1, id_rs1, id_rs2, id_rd, id_rd1, id_rd2, id_imm, id_pc,
                       id_srca, id_srcb, id_alucontrol, id_regwrite};
        end else begin
            m.v1 <= newest(m.rs1, m.v1);
            m.v2 <= newest(m.rs2, m.v2);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!reset) begin
            chk("ex_valid", {31'd0, ex_valid}, {31'd0, m.valid});
            chk("id_ready", {31'd0, id_ready}, {31'd0, (!m.valid || ex_ready)});
            if (m.valid) begin
                chk("alu_a", alu_a, exp_a());
                chk("alu_b", alu_b, exp_b());
                chk("store_data", ex_store_data, newest(m.rs2, m.v2));
                chk("alu_control", {28'd0, alu_control}, {28'd0, m.ctrl});
                chk("ex_rd", {27'd0, ex_rd}, {27'd0, m.rd});
                chk("ex_regwrite", {31'd0, ex_regwrite}, {31'd0, m.we});
                chk("ex_pc", ex_pc, m.pc);
                chk("ex_imm", ex_imm, m.imm);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic [31:0] v1,
                          input logic [4:0] rs2, input logic [31:0] v2,
                          input logic [1:0] sa, input logic sb, input logic [31:0] imm,
                          input logic [31:0] pc, input logic [3:0] ctrl);
        id_valid = 1'b1; id_rs1 = rs1; id_rd1 = v1; id_rs2 = rs2; id_rd2 = v2;
        id_srca = sa; id_srcb = sb; id_imm = imm; id_pc = pc; id_alucontrol = ctrl;
        id_rd = 5'd3; id_regwrite = 1'b1;
    endtask

    initial begin
        reset = 1'b1; id_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0; id_rd1 = 32'd0; id_rd2 = 32'd0;
        id_imm = 32'd0; id_pc = 32'd0; id_srca = 2'b00; id_srcb = 1'b0;
        id_alucontrol = 4'd0; id_regwrite = 1'b0;
        mem_regwrite = 1'b0; mem_rd = 5'd0; mem_result = 32'd0;
        wb_regwrite = 1'b0; wb_rd = 5'd0; wb_result = 32'd0;
        #12 reset = 1'b0;

        // Reset state
        mid();
        chk("rst ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst alu_a", alu_a, 32'd0);
        chk("rst alu_b", alu_b, 32'd0);
        chk("rst id_ready", {31'd0, id_ready}, 32'd1);

        // 1: add x1(5), x2(7)
        set_id(5'd1, 32'd5, 5'd2, 32'd7, 2'b00, 1'b0, 32'd0, 32'h40, 4'b0000);
        tick(); id_valid = 1'b0;
        mid();
        chk("t1 ex_valid", {31'd0, ex_valid}, 32'd1);
        chk("t1 alu_a", alu_a, 32'd5);
        chk("t1 alu_b", alu_b, 32'd7);
        chk("t1 ctrl", {28'd0, alu_control}, 32'd0);

        // 2: MEM and WB both target x1, MEM wins; then WB alone
        mem_regwrite = 1'b1; mem_rd = 5'd1; mem_result = 32'h10;
        wb_regwrite = 1'b1; wb_rd = 5'd1; wb_result = 32'h20;
        #1 chk("t2 mem prio", alu_a, 32'h10);
        mem_regwrite = 1'b0;
        #1 chk("t2 wb fwd", alu_a, 32'h20);
        wb_regwrite = 1'b0;

        // 3: x0 never forwarded
        set_id(5'd0, 32'd0, 5'd2, 32'd7, 2'b00, 1'b0, 32'd0, 32'h44, 4'b0001);
        mem_regwrite = 1'b1; mem_rd = 5'd0; mem_result = 32'hFFFF;
        tick(); id_valid = 1'b0;
        mid();
        chk("t3 x0", alu_a, 32'd0);
        mem_regwrite = 1'b0;

        // 4: three-cycle stall, WB x2=0x99 only during the first stalled cycle
        set_id(5'd1, 32'd5, 5'd2, 32'd7, 2'b00, 1'b0, 32'd0, 32'h48, 4'b0010);
        tick();
        ex_ready = 1'b0;
        wb_regwrite = 1'b1; wb_rd = 5'd2; wb_result = 32'h99;
        set_id(5'd4, 32'h44, 5'd0, 32'd0, 2'b00, 1'b0, 32'd0, 32'h4C, 4'b0011);
        mid();
        chk("t4 b c1", alu_b, 32'h99);
        chk("t4 rdy c1", {31'd0, id_ready}, 32'd0);
        tick(); wb_regwrite = 1'b0;
        mid();
        chk("t4 b c2", alu_b, 32'h99);
        chk("t4 rdy c2", {31'd0, id_ready}, 32'd0);
        tick();
        mid();
        chk("t4 b c3", alu_b, 32'h99);
        chk("t4 rdy c3", {31'd0, id_ready}, 32'd0);
        ex_ready = 1'b1;
        #1 chk("t4 rdy release", {31'd0, id_ready}, 32'd1);
        tick(); id_valid = 1'b0;
        mid();
        chk("t4 next accepted", {31'd0, ex_valid}, 32'd1);
        chk("t4 next a", alu_a, 32'h44);

        // 5: PC / immediate select, store data independent of srcb
        mem_regwrite = 1'b1; mem_rd = 5'd5; mem_result = 32'h77;
        set_id(5'd1, 32'd5, 5'd5, 32'h55, 2'b01, 1'b1, 32'hFFFFFFFC, 32'h100, 4'b0111);
        tick(); id_valid = 1'b0;
        mid();
        chk("t5 a pc", alu_a, 32'h100);
        chk("t5 b imm", alu_b, 32'hFFFFFFFC);
        chk("t5 store", ex_store_data, 32'h77);
        chk("t5 ctrl", {28'd0, alu_control}, 32'd7);
        set_id(5'd1, 32'd5, 5'd5, 32'h55, 2'b10, 1'b0, 32'd0, 32'h104, 4'b1000);
        tick(); id_valid = 1'b0;
        mid();
        chk("t5 a zero", alu_a, 32'd0);
        chk("t5 b fwd", alu_b, 32'h77);
        set_id(5'd1, 32'd5, 5'd5, 32'h55, 2'b11, 1'b0, 32'd0, 32'h108, 4'b1001);
        tick(); id_valid = 1'b0;
        mid();
        chk("t5 a rsvd", alu_a, 32'd5);
        mem_regwrite = 1'b0;

        // Back-to-back burst at full throughput
        for (int i = 0; i < 4; i++) begin
            set_id(5'(i + 6), 32'(i * 3), 5'(i + 7), 32'(i * 5 + 1), 2'b00, 1'b0,
                   32'd0, 32'(32'h200 + i * 4), 4'(i));
            tick();
        end
        id_valid = 1'b0;
        mid();
        chk("burst last a", alu_a, 32'd9);
        chk("burst last b", alu_b, 32'd16);

        // 6: flush with incoming instruction, then async reset during a stall
        set_id(5'd1, 32'd1, 5'd2, 32'd2, 2'b00, 1'b0, 32'd0, 32'h300, 4'd0);
        flush = 1'b1;
        #1 chk("t6 rdy flush", {31'd0, id_ready}, 32'd1);
        tick(); flush = 1'b0; id_valid = 1'b0;
        mid();
        chk("t6 flushed", {31'd0, ex_valid}, 32'd0);
        set_id(5'd1, 32'h11, 5'd2, 32'h22, 2'b00, 1'b0, 32'd0, 32'h304, 4'd1);
        tick(); id_valid = 1'b0; ex_ready = 1'b0;
        tick();
        mid();
        chk("t6 stalled", {31'd0, ex_valid}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("t6 async rst valid", {31'd0, ex_valid}, 32'd0);
        chk("t6 async rst a", alu_a, 32'd0);
        chk("t6 async rst b", alu_b, 32'd0);
        reset = 1'b0;
        ex_ready = 1'b1;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
